// File: rtl/systolic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared types, defaults and helpers for the systolic array
//                sequencer, the array top and its testbench.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Rows plus columns of skew through the array, plus one activation read cycle
    function automatic int out_lat_default(input int dim);
        return 2 * dim + 1;
    endfunction

    localparam int ARRAY_DIM_DEF = 4;
    localparam int VEC_W_DEF     = 8;
    localparam int OUT_LAT_DEF   = out_lat_default(ARRAY_DIM_DEF);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : systolic_ctrl
//  Description : Job sequencer for a weight-stationary systolic array:
//                weight tile load, activation streaming with stall, and
//                result drain into the output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter  int ARRAY_DIM = ARRAY_DIM_DEF,
    parameter  int VEC_W     = VEC_W_DEF,
    parameter  int OUT_LAT   = out_lat_default(ARRAY_DIM),
    localparam int AW        = (clog2(ARRAY_DIM) < 1) ? 1 : clog2(ARRAY_DIM)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [VEC_W-1:0] num_vec,
    input  logic             stall,
    output logic             w_rd_en,
    output logic [AW-1:0]    w_rd_addr,
    output logic             wwrite,
    output logic             a_rd_en,
    output logic [VEC_W-1:0] a_rd_addr,
    output logic             active,
    output logic             o_wr_en,
    output logic [VEC_W-1:0] o_wr_addr,
    output logic             busy,
    output logic             done
);

    // Run counter carries one extra bit so k can reach M+OUT_LAT-1 unwrapped;
    // comparisons use one more bit again so OUT_LAT+M never overflows.
    localparam int               KW        = VEC_W + 1;
    localparam int               SW        = VEC_W + 2;
    localparam logic [SW-1:0]    OUT_LAT_S = SW'(OUT_LAT);
    localparam logic [VEC_W-1:0] OUT_LAT_V = VEC_W'(OUT_LAT);
    localparam logic [AW-1:0]    LAST_ROW  = AW'(ARRAY_DIM - 1);

    state_e           state_q,     state_d;
    logic [AW-1:0]    load_cnt_q,  load_cnt_d;
    logic [KW-1:0]    run_cnt_q,   run_cnt_d;
    logic [VEC_W-1:0] num_vec_q,   num_vec_d;
    logic             w_rd_en_q,   w_rd_en_d;
    logic [AW-1:0]    w_rd_addr_q, w_rd_addr_d;
    logic             wwrite_q,    wwrite_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic [SW-1:0]    w_k_s;
    logic [SW-1:0]    w_m_s;
    logic [SW-1:0]    w_wr_end;
    logic [SW-1:0]    w_last_k;
    logic [VEC_W-1:0] w_wr_idx;
    logic             w_advance;
    logic             w_in_read;
    logic             w_in_write;

    assign w_k_s      = {1'b0, run_cnt_q};
    assign w_m_s      = {2'b00, num_vec_q};
    assign w_wr_end   = OUT_LAT_S + w_m_s;
    assign w_last_k   = w_wr_end - SW'(1);
    assign w_wr_idx   = run_cnt_q[VEC_W-1:0] - OUT_LAT_V;
    assign w_advance  = (state_q == S_RUN) && !stall;
    assign w_in_read  = (w_k_s < w_m_s);
    assign w_in_write = (w_k_s >= OUT_LAT_S) && (w_k_s < w_wr_end);

    // The stall input must gate the array edge in the same cycle it is seen,
    // so the RUN-phase strobes are decoded from registered state and stall.
    assign active    = w_advance;
    assign a_rd_en   = w_advance && w_in_read;
    assign a_rd_addr = (w_advance && w_in_read) ? run_cnt_q[VEC_W-1:0] : '0;
    assign o_wr_en   = w_advance && w_in_write;
    assign o_wr_addr = (w_advance && w_in_write) ? w_wr_idx : '0;

    assign w_rd_en   = w_rd_en_q;
    assign w_rd_addr = w_rd_addr_q;
    assign wwrite    = wwrite_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state and next-output decode for the job sequencer
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        run_cnt_d   = run_cnt_q;
        num_vec_d   = num_vec_q;
        w_rd_en_d   = 1'b0;
        w_rd_addr_d = '0;
        // One-cycle delay matches the weight SRAM read latency
        wwrite_d    = w_rd_en_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_vec_d = num_vec;
                    if (num_vec == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_LOAD;
                        load_cnt_d  = '0;
                        w_rd_en_d   = 1'b1;
                        w_rd_addr_d = LAST_ROW;
                    end
                end
            end
            S_LOAD: begin
                // Rows are read last-to-first so row 0 ends up in the top PE row
                if (load_cnt_q == LAST_ROW) begin
                    state_d    = S_SETTLE;
                    load_cnt_d = '0;
                end else begin
                    load_cnt_d  = load_cnt_q + AW'(1);
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = LAST_ROW - (load_cnt_q + AW'(1));
                end
            end
            S_SETTLE: begin
                state_d   = S_RUN;
                run_cnt_d = '0;
            end
            S_RUN: begin
                if (!stall) begin
                    if (w_k_s == w_last_k) begin
                        state_d   = S_DONE;
                        run_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_cnt_q + KW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, counters and registered outputs; reset abandons any job at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            run_cnt_q   <= '0;
            num_vec_q   <= '0;
            w_rd_en_q   <= 1'b0;
            w_rd_addr_q <= '0;
            wwrite_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            run_cnt_q   <= run_cnt_d;
            num_vec_q   <= num_vec_d;
            w_rd_en_q   <= w_rd_en_d;
            w_rd_addr_q <= w_rd_addr_d;
            wwrite_q    <= wwrite_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_ctrl
//  Description : Self-checking bench for systolic_ctrl with a cycle-level
//                behavioural model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int D  = ARRAY_DIM_DEF;
    localparam int VW = VEC_W_DEF;
    localparam int OL = out_lat_default(D);
    localparam int AW = (clog2(D) < 1) ? 1 : clog2(D);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [VW-1:0] num_vec = '0;
    logic          stall = 1'b0;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          wwrite;
    logic          a_rd_en;
    logic [VW-1:0] a_rd_addr;
    logic          active;
    logic          o_wr_en;
    logic [VW-1:0] o_wr_addr;
    logic          busy;
    logic          done;

    systolic_ctrl #(.ARRAY_DIM(D), .VEC_W(VW), .OUT_LAT(OL)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .num_vec   (num_vec),
        .stall     (stall),
        .w_rd_en   (w_rd_en),
        .w_rd_addr (w_rd_addr),
        .wwrite    (wwrite),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .active    (active),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a job is a timeline measured from the accepting edge. m_t is the
    // cycle index within the job (1 = first LOAD cycle), m_n is how many
    // non-stalled RUN cycles have elapsed, m_M the latched vector count.
    bit m_job  = 1'b0;
    bit m_done = 1'b0;
    int m_t    = 0;
    int m_n    = 0;
    int m_M    = 0;

    // Advance the model at each clock edge from the inputs sampled there
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_job  <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
            m_n    <= 0;
            m_M    <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_job) begin
            m_t <= m_t + 1;
            if (m_t >= D + 2 && !stall) begin
                m_n <= m_n + 1;
                if (m_n + 1 == OL + m_M) begin
                    m_job  <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (start) begin
            m_M <= int'(num_vec);
            m_n <= 0;
            if (num_vec == '0) begin
                m_done <= 1'b1;
            end else begin
                m_job <= 1'b1;
                m_t   <= 1;
            end
        end
    end

    // Compare every output against the model in the middle of each cycle
    always @(negedge clock) begin
        chk("busy", busy, 32'(m_job || m_done));
        chk("done", done, 32'(m_done));
        chk("w_rd_en", w_rd_en, 32'(m_job && m_t >= 1 && m_t <= D));
        if (m_job && m_t >= 1 && m_t <= D)
            chk("w_rd_addr", w_rd_addr, 32'(D - m_t));
        chk("wwrite", wwrite, 32'(m_job && m_t >= 2 && m_t <= D + 1));
        chk("active", active, 32'(m_job && m_t >= D + 2 && !stall));
        chk("a_rd_en", a_rd_en, 32'(m_job && m_t >= D + 2 && !stall && m_n < m_M));
        if (m_job && m_t >= D + 2 && !stall && m_n < m_M)
            chk("a_rd_addr", a_rd_addr, 32'(m_n));
        chk("o_wr_en", o_wr_en,
            32'(m_job && m_t >= D + 2 && !stall && m_n >= OL && m_n < OL + m_M));
        if (m_job && m_t >= D + 2 && !stall && m_n >= OL && m_n < OL + m_M)
            chk("o_wr_addr", o_wr_addr, 32'((m_n - OL) % 256));
    end

    // Per-cycle logs of a directed job, -1 meaning "strobe low"
    int w_log[64];
    int a_log[64];
    int o_log[64];
    bit ww_log[64];
    bit act_log[64];
    bit done_log[64];
    bit busy_log[64];

    task automatic run_directed(input int m, input int st_cyc, input int st_n,
                                input int rs_cyc, input int ncyc);
        for (int i = 0; i < 64; i++) begin
            w_log[i] = -1; a_log[i] = -1; o_log[i] = -1;
            ww_log[i] = 0; act_log[i] = 0; done_log[i] = 0; busy_log[i] = 0;
        end
        num_vec = VW'(m);
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int cy = 1; cy <= ncyc; cy++) begin
            stall = (cy >= st_cyc && cy < st_cyc + st_n);
            start = (cy == rs_cyc);
            if (cy == rs_cyc) num_vec = 8'd7;
            @(negedge clock);
            w_log[cy]    = w_rd_en ? int'(w_rd_addr) : -1;
            a_log[cy]    = a_rd_en ? int'(a_rd_addr) : -1;
            o_log[cy]    = o_wr_en ? int'(o_wr_addr) : -1;
            ww_log[cy]   = wwrite;
            act_log[cy]  = active;
            done_log[cy] = done;
            busy_log[cy] = busy;
            @(posedge clock); #1;
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    function automatic int done_count(input int ncyc);
        int n;
        n = 0;
        for (int i = 1; i <= ncyc; i++) n += int'(done_log[i]);
        return n;
    endfunction

    int cnt;
    int mx;
    int last;
    bit seen;

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("reset outputs",
            {busy, done, w_rd_en, w_rd_addr, wwrite, a_rd_en, a_rd_addr,
             active, o_wr_en, o_wr_addr}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // M=3, no stall
        run_directed(3, 0, 0, 0, 20);
        for (int i = 0; i < 4; i++) chk("load w_rd_addr", w_log[1 + i], 32'(3 - i));
        chk("no read cycle 5", w_log[5], -1);
        for (int cy = 1; cy <= 7; cy++) chk("wwrite window", ww_log[cy], 32'(cy >= 2 && cy <= 5));
        for (int i = 0; i < 3; i++) chk("a_rd_addr seq", a_log[6 + i], 32'(i));
        chk("a_rd none after", a_log[9], -1);
        chk("o_wr before", o_log[14], -1);
        for (int i = 0; i < 3; i++) chk("o_wr_addr seq", o_log[15 + i], 32'(i));
        chk("done cycle 18", done_log[18], 1);
        chk("done count", done_count(20), 1);
        chk("busy after done", busy_log[19], 0);

        // M=3, stall in cycles 7 and 8 (RUN k=1)
        run_directed(3, 7, 2, 0, 22);
        chk("stall active 6", act_log[6], 1);
        chk("stall active 7", act_log[7], 0);
        chk("stall active 8", act_log[8], 0);
        chk("stall a_rd 7", a_log[7], -1);
        chk("stall a_rd 8", a_log[8], -1);
        chk("resume a_rd 9", a_log[9], 1);
        chk("resume a_rd 10", a_log[10], 2);
        for (int i = 0; i < 3; i++) chk("stall o_wr seq", o_log[17 + i], 32'(i));
        chk("stall done 20", done_log[20], 1);
        chk("stall done count", done_count(22), 1);

        // num_vec = 0
        run_directed(0, 0, 0, 0, 4);
        chk("zero done 1", done_log[1], 1);
        chk("zero busy 1", busy_log[1], 1);
        chk("zero busy 2", busy_log[2], 0);
        cnt = 0;
        for (int cy = 1; cy <= 4; cy++)
            cnt += int'(w_log[cy] != -1) + int'(ww_log[cy]) + int'(act_log[cy]) + int'(o_log[cy] != -1);
        chk("zero no strobes", cnt, 0);

        // start pulsed during RUN, then a normal job
        run_directed(3, 0, 0, 10, 24);
        chk("restart done 18", done_log[18], 1);
        chk("restart done count", done_count(24), 1);
        run_directed(2, 0, 0, 0, 20);
        chk("next job done 17", done_log[17], 1);
        chk("next job a_rd", a_log[7], 1);

        // reset in the middle of RUN
        num_vec = 8'd5;
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        chk("pre-reset active", active, 1);
        reset = 1'b1;
        #1;
        chk("mid-run reset outputs",
            {busy, done, w_rd_en, w_rd_addr, wwrite, a_rd_en, a_rd_addr,
             active, o_wr_en, o_wr_addr}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        cnt = 0;
        mx  = 0;
        for (int cy = 0; cy < 30; cy++) begin
            @(negedge clock);
            cnt += int'(done);
            mx  += int'(busy);
        end
        chk("reset no done", cnt, 0);
        chk("reset idle", mx, 0);
        @(posedge clock); #1;

        // M=255 with light stalls
        num_vec = 8'd255;
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cnt  = 0;
        mx   = 0;
        last = -1;
        seen = 1'b0;
        for (int cy = 0; cy < 1500 && !seen; cy++) begin
            stall = ($urandom_range(0, 7) == 0);
            @(negedge clock);
            if (o_wr_en) begin
                cnt++;
                last = int'(o_wr_addr);
                if (int'(o_wr_addr) > mx) mx = int'(o_wr_addr);
            end
            if (done) seen = 1'b1;
            @(posedge clock); #1;
        end
        stall = 1'b0;
        chk("big done seen", seen, 1);
        chk("big o_wr count", cnt, 255);
        chk("big o_wr max", mx, 254);
        chk("big o_wr last", last, 254);
        repeat (2) @(posedge clock);
        #1;

        // Random traffic, all checked by the model
        for (int cy = 0; cy < 3000; cy++) begin
            start   = ($urandom_range(0, 5) == 0);
            num_vec = ($urandom_range(0, 9) == 0) ? VW'($urandom_range(0, 255))
                                                  : VW'($urandom_range(0, 20));
            stall   = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
            end else begin
                @(posedge clock); #1;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
